// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser plus per-bit debounce counters for slide switches
module switch_debouncer #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  // Counter value on which a persisting new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] diff;

  // Next-state: synchroniser shift, per-bit run counters and acceptance strobes.
  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    diff     = sync2_q ^ stable_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Any cycle matching the stable level restarts the run from zero.
      cnt_d[i] = '0;
      if (diff[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // State registers; reset discards counters and forces every output low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_stable  = stable_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sw_changed = changed_q;

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw DE-board slide switches before they reach the Nios switch PIO input port.
- Each bit is synchronised into clk, then debounced by its own counter.
- Outputs a clean stable vector for the PIO in_port, plus one-cycle rise/fall strobes and an any-change strobe for interrupt/edge logic.
- Sits between the top-level switch pins and the Avalon PIO slave in the nios_hps_system.

Parameters:
WIDTH, 10, number of switch bits.
DEBOUNCE_CYCLES, 500000, consecutive clk cycles a new level must persist before acceptance (10 ms at 50 MHz); legal range 1..2^CNT_W-1.
CNT_W, 20, width of each per-bit counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
sw_raw  in  WIDTH  raw asynchronous switch pins.
sw_stable  out  WIDTH  debounced level; drives PIO in_port.
sw_rise  out  WIDTH  1-cycle strobe per bit on accepted 0->1.
sw_fall  out  WIDTH  1-cycle strobe per bit on accepted 1->0.
sw_changed  out  1  1-cycle strobe, OR of sw_rise|sw_fall.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. While reset_n=0, all of the following are 0 regardless of sw_raw:
  - sync stages,
  - counters,
  - sw_stable, sw_rise, sw_fall, sw_changed.
- Synchroniser: 2-flop chain per bit (sync1 <= sw_raw, sync2 <= sync1). Only sync2 feeds the debounce logic. No combinational path from sw_raw to any output.
- Per-bit debounce, evaluated on every clk edge, with d = (sync2[i] != sw_stable[i]):
  - d=0: cnt[i] <= 0.
  - d=1 and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - d=1 and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= sync2[i]; cnt[i] <= 0; the matching strobe (sw_rise[i] if sync2[i]=1, else sw_fall[i]) is 1 for exactly that next cycle.
- Latency: a clean level change on sw_raw set up before edge k becomes visible on sw_stable after edge k+1+DEBOUNCE_CYCLES.
  - Sync2 changes after edge k+1.
  - Then DEBOUNCE_CYCLES qualifying edges are needed.
- Glitch rejection: any excursion of sync2 lasting fewer than DEBOUNCE_CYCLES cycles produces no output change and no strobe. The counter restarts from 0 on the first cycle sync2 re-matches sw_stable.
- Bouncing: the counter resets on every return to the stable level, so acceptance requires DEBOUNCE_CYCLES uninterrupted cycles of the new level.
- Strobes:
  - Registered; high for exactly one cycle per accepted transition; 0 otherwise.
  - Several bits may strobe in the same cycle.
  - sw_changed is registered in the same cycle as the per-bit strobes (no extra latency).
- Bits are fully independent; simultaneous transitions on different bits are each accepted on their own schedule.
- DEBOUNCE_CYCLES=1: the block degenerates to synchroniser plus 1-cycle register; acceptance happens on the first differing edge.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
- Reset mid-operation: counters are discarded and sw_stable forced to 0. After release, bits whose switch is high re-qualify as a normal 0->1 transition, taking 2+DEBOUNCE_CYCLES cycles, and generate sw_rise.
- Switches already on at power-up therefore produce sw_rise strobes once after reset; downstream software must tolerate this.

Test Plan:
1. DEBOUNCE_CYCLES=8, reset, hold sw_raw=0x000 for 20 cycles -> all outputs 0, no strobes.
2. After reset, step sw_raw from 0x000 to 0x005 before edge k, hold -> sw_stable=0x005 after edge k+9; sw_rise=0x005 and sw_changed=1 for exactly that one cycle; sw_fall=0.
3. sw_stable=0x005; pulse sw_raw bit 0 low for 7 cycles, then restore -> sw_stable stays 0x005, no strobes. Repeat with 8 cycles low -> sw_fall=0x001 for one cycle, sw_stable=0x004.
4. Bouncing input: bit 9 toggles 0/1 every 3 cycles for 30 cycles, then holds 1 -> no change during bouncing; sw_stable[9]=1 exactly 8 cycles after sync2 settles; single sw_rise[9].
5. Simultaneous events: bit 1 rises and bit 2 falls in the same cycle from sw_stable=0x004 -> one cycle with sw_rise=0x002, sw_fall=0x004, sw_changed=1; then sw_stable=0x002.
6. Assert reset_n for 1 cycle while bit 3's counter is at 5 of 8 -> outputs 0 immediately (asynchronously). With sw_raw=0x008 held after release -> sw_stable=0x008 after 10 edges, with one sw_rise=0x008.
